conv_accumulate_relu: RTL

Post-processing stage directly downstream of the final (L4) adder of the convolution adder tree. It accumulates `num_passes` consecutive 20-bit signed partial sums, one per input-channel pass, into one output pixel. It then adds a per-filter bias, applies ReLU, rounds and right-shifts to requantize, and saturates to an unsigned activation. The result is presented on a valid/ready output towards the feature-map buffer, with full backpressure to the adder tree.

---
 rtl/conv_accumulate_relu.sv | 131 +++++++++++++
 1 files changed

// File: rtl/conv_accumulate_relu.sv
// Accumulates num_passes signed partial sums per pixel, adds a per-filter bias, applies ReLU,
// rounds half up, requantizes by a right shift and saturates to an unsigned activation.
module conv_accumulate_relu #(
  parameter int in_width   = 20,
  parameter int acc_width  = 24,
  parameter int bias_width = 16,
  parameter int num_passes = 4,
  parameter int shift      = 6,
  parameter int out_width  = 8,
  localparam int CW = (num_passes > 1) ? $clog2(num_passes) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [in_width-1:0]   in_data,
  input  logic [bias_width-1:0] bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [out_width-1:0]  out_data,
  output logic [CW-1:0]         pass_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {ST_ACC = 2'd0, ST_POST = 2'd1, ST_OUT = 2'd2} state_t;

  localparam logic signed [acc_width-1:0] HALF    = acc_width'(1) << (shift - 1);
  localparam logic signed [acc_width-1:0] MAX_OUT = acc_width'((1 << out_width) - 1);

  state_t                       r_state;
  state_t                       w_next_state;
  logic signed [acc_width-1:0]  r_acc;
  logic [bias_width-1:0]        r_bias;
  logic [CW-1:0]                r_cnt;
  logic                         r_out_valid;
  logic [out_width-1:0]         r_out_data;

  logic                         w_accept;
  logic                         w_last;
  logic                         w_out_fire;
  logic signed [acc_width-1:0]  w_in_ext;
  logic signed [acc_width-1:0]  w_bias_ext;
  logic signed [acc_width-1:0]  w_sum;
  logic signed [acc_width-1:0]  w_round;
  logic signed [acc_width-1:0]  w_r;
  logic [out_width-1:0]         w_post_data;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid && ready;
  // in_ready depends only on state, so there is no path from out_ready to in_ready.
  assign in_ready   = (r_state == ST_ACC);
  assign w_accept   = in_valid && in_ready && !clear;
  assign w_last     = (r_cnt == CW'(num_passes - 1));
  assign w_out_fire = r_out_valid && out_ready;

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign pass_cnt   = r_cnt;
  assign dbg_state  = r_state;

  assign w_in_ext   = {{(acc_width - in_width){in_data[in_width-1]}}, in_data};
  assign w_bias_ext = {{(acc_width - bias_width){r_bias[bias_width-1]}}, r_bias};
  assign w_sum      = r_acc + w_bias_ext;
  assign w_round    = w_sum + HALF;
  assign w_r        = w_round >>> shift;

  always_comb begin
    w_post_data = w_r[out_width-1:0];
    if (w_sum[acc_width-1]) begin
      w_post_data = '0;
    end else if (w_r > MAX_OUT) begin
      w_post_data = '1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ACC:  if (w_accept && w_last) w_next_state = ST_POST;
      ST_POST: w_next_state = ST_OUT;
      ST_OUT:  if (w_out_fire) w_next_state = ST_ACC;
      default: w_next_state = ST_ACC;
    endcase
    if (clear) begin
      w_next_state = ST_ACC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_bias <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      // First beat of a pixel restarts the sum and latches the bias for this filter.
      if (r_cnt == '0) begin
        r_acc  <= w_in_ext;
        r_bias <= bias;
      end else begin
        r_acc <= r_acc + w_in_ext;
      end
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (r_state == ST_POST) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_post_data;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
